pwl_ctrl: RTL and testbench

Sequencing and configuration controller for the piecewise-linear (PWL) nth-root approximation datapath. Holds the double-buffered breakpoint/slope/intercept table, arbitrates two requesters onto the single datapath, and tracks in-flight operands by tag. Results are returned to the originating requester, and the active table is never changed while operands are in flight.

---
 rtl/pwl_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pwl_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_ctrl.sv
// pwl_ctrl: sequencing/configuration controller for the PWL nth-root datapath.
//
// Holds a double-buffered table (9 breakpoints, 10 slopes, 10 intercepts),
// round-robin arbitrates two requesters onto one datapath, and tags every
// in-flight operand so its result goes back to the requester that sent it.
// The active table is only swapped once the datapath is empty.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   cfg_we/addr/wdata      shadow-table write (0-8 x, 9-18 k, 19-28 b)
//   cfg_commit             request shadow->active copy
//   cfg_busy, tbl_valid    commit in progress / table committed since reset
//   reqN_valid/x/ready     requester operand handshakes (N = 0, 1)
//   dp_x, dp_xn, dp_k, dp_b  operand and active table to the datapath
//   dp_out                 datapath result, LAT cycles after dp_x
//   rsp_valid/id/data      one-cycle result strobe back to the requesters
module pwl_ctrl #(
    parameter int unsigned W   = 14,
    parameter int unsigned LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [4:0]      cfg_addr,
    input  logic [W-1:0]    cfg_wdata,
    input  logic            cfg_commit,
    output logic            cfg_busy,
    output logic            tbl_valid,
    input  logic            req0_valid,
    input  logic [W-1:0]    req0_x,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [W-1:0]    req1_x,
    output logic            req1_ready,
    output logic [W-1:0]    dp_x,
    output logic [9*W-1:0]  dp_xn,
    output logic [10*W-1:0] dp_k,
    output logic [10*W-1:0] dp_b,
    input  logic [2*W-1:0]  dp_out,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [2*W-1:0]  rsp_data
);

    // In-flight count spans 0..LAT+1 (tag stages 0..LAT).
    localparam int unsigned CntW = $clog2(LAT + 2);

    typedef enum logic [1:0] {StInit, StRun, StDrain, StUpdate} state_e;

    state_e         state_q;
    logic           cfg_busy_q;
    logic           tbl_valid_q;

    logic [W-1:0]   sh_x_q  [9];
    logic [W-1:0]   sh_k_q  [10];
    logic [W-1:0]   sh_b_q  [10];
    logic [W-1:0]   act_x_q [9];
    logic [W-1:0]   act_k_q [10];
    logic [W-1:0]   act_b_q [10];

    logic           rr_pref1_q;  // 1: req1 wins a tie next time
    logic [W-1:0]   dp_x_q;
    // Stage 0 travels with dp_x; stage LAT lines up with the matching dp_out.
    logic [LAT:0]   tag_v_q;
    logic [LAT:0]   tag_id_q;
    logic [CntW-1:0] inflight_q;
    logic           rsp_valid_q;
    logic           rsp_id_q;
    logic [2*W-1:0] rsp_data_q;

    logic           gnt0;
    logic           gnt1;
    logic           issue;
    logic [W-1:0]   issue_x;
    logic           ret;

    // Grant logic: combinational so a requester sees ready in the same cycle.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (state_q == StRun) begin
            gnt0 = req0_valid & (~req1_valid | ~rr_pref1_q);
            gnt1 = req1_valid & (~req0_valid | rr_pref1_q);
        end
        issue   = gnt0 | gnt1;
        issue_x = gnt1 ? req1_x : req0_x;
        ret     = tag_v_q[LAT];
    end

    // Shadow table: writable in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) sh_x_q[i] <= '0;
            for (int i = 0; i < 10; i++) begin
                sh_k_q[i] <= '0;
                sh_b_q[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < 9; i++) begin
                if (cfg_addr == 5'(i)) sh_x_q[i] <= cfg_wdata;
            end
            for (int i = 0; i < 10; i++) begin
                if (cfg_addr == 5'(i + 9))  sh_k_q[i] <= cfg_wdata;
                if (cfg_addr == 5'(i + 19)) sh_b_q[i] <= cfg_wdata;
            end
        end
    end

    // Control FSM with its registered status outputs and the active table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            cfg_busy_q  <= 1'b0;
            tbl_valid_q <= 1'b0;
            for (int i = 0; i < 9; i++) act_x_q[i] <= '0;
            for (int i = 0; i < 10; i++) begin
                act_k_q[i] <= '0;
                act_b_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StInit: begin
                    if (cfg_commit) begin
                        state_q    <= StUpdate;
                        cfg_busy_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (cfg_commit) begin
                        state_q    <= StDrain;
                        cfg_busy_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (inflight_q == '0) state_q <= StUpdate;
                end
                StUpdate: begin
                    // Copies the pre-edge shadow; a same-cycle write stays in the shadow.
                    for (int i = 0; i < 9; i++) act_x_q[i] <= sh_x_q[i];
                    for (int i = 0; i < 10; i++) begin
                        act_k_q[i] <= sh_k_q[i];
                        act_b_q[i] <= sh_b_q[i];
                    end
                    tbl_valid_q <= 1'b1;
                    cfg_busy_q  <= 1'b0;
                    state_q     <= StRun;
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // Issue, tag tracking and result return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_pref1_q  <= 1'b0;
            dp_x_q      <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            inflight_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (issue) begin
                dp_x_q     <= issue_x;
                rr_pref1_q <= ~gnt1;
            end
            tag_v_q     <= {tag_v_q[LAT-1:0], issue};
            tag_id_q    <= {tag_id_q[LAT-1:0], gnt1};
            rsp_valid_q <= ret;
            if (ret) begin
                rsp_id_q   <= tag_id_q[LAT];
                rsp_data_q <= dp_out;
            end
            case ({issue, ret})
                2'b10:   inflight_q <= inflight_q + CntW'(1);
                2'b01:   inflight_q <= inflight_q - CntW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_xn
        assign dp_xn[i*W +: W] = act_x_q[i];
    end
    for (genvar i = 0; i < 10; i++) begin : g_kb
        assign dp_k[i*W +: W] = act_k_q[i];
        assign dp_b[i*W +: W] = act_b_q[i];
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign cfg_busy   = cfg_busy_q;
    assign tbl_valid  = tbl_valid_q;
    assign dp_x       = dp_x_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_pwl_ctrl.sv
// Self-checking bench for pwl_ctrl. A behavioural LAT-cycle datapath drives
// dp_out; expected responses are queued at grant time and checked on rsp_valid.
module tb_pwl_ctrl;

    localparam int unsigned W   = 14;
    localparam int unsigned LAT = 4;

    logic            clk;
    logic            rst_n;
    logic            cfg_we;
    logic [4:0]      cfg_addr;
    logic [W-1:0]    cfg_wdata;
    logic            cfg_commit;
    logic            cfg_busy;
    logic            tbl_valid;
    logic            req0_valid;
    logic [W-1:0]    req0_x;
    logic            req0_ready;
    logic            req1_valid;
    logic [W-1:0]    req1_x;
    logic            req1_ready;
    logic [W-1:0]    dp_x;
    logic [9*W-1:0]  dp_xn;
    logic [10*W-1:0] dp_k;
    logic [10*W-1:0] dp_b;
    logic [2*W-1:0]  dp_out;
    logic            rsp_valid;
    logic            rsp_id;
    logic [2*W-1:0]  rsp_data;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic           id;
        logic [2*W-1:0] data;
        int             cyc;
    } exp_t;
    exp_t sb[$];

    // Bench copies of the shadow and active tables.
    logic [9*W-1:0]  s_xn = '0, m_xn = '0;
    logic [10*W-1:0] s_k = '0, m_k = '0, s_b = '0, m_b = '0;

    pwl_ctrl #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .tbl_valid(tbl_valid),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_ready(req1_ready),
        .dp_x(dp_x), .dp_xn(dp_xn), .dp_k(dp_k), .dp_b(dp_b), .dp_out(dp_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Segment = number of breakpoints at or below x; result = k*x + b.
    function automatic logic [2*W-1:0] pwl(input logic [W-1:0] x, input logic [9*W-1:0] xn,
                                            input logic [10*W-1:0] k, input logic [10*W-1:0] b);
        int seg = 0;
        logic signed [W-1:0]   xs, xi, ki, bi;
        logic signed [2*W-1:0] xw, kw, bw;
        xs = x;
        for (int i = 0; i < 9; i++) begin
            xi = xn[i*W +: W];
            if (xs >= xi) seg = i + 1;
        end
        ki = k[seg*W +: W];
        bi = b[seg*W +: W];
        xw = xs;
        kw = ki;
        bw = bi;
        return kw * xw + bw;
    endfunction

    // Behavioural datapath: result of dp_x appears LAT cycles later.
    logic [W-1:0] pipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        pipe[0] <= dp_x;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_out = pwl(pipe[LAT-1], dp_xn, dp_k, dp_b);

    // Response monitor / scoreboard checker.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL rsp_unexpected: got id=%0d data=%0h at cyc %0d, required none",
                         rsp_id, rsp_data, cyc);
            end else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_data !== e.data || cyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL rsp_match: got id=%0d data=%0h cyc=%0d, required id=%0d data=%0h cyc=%0d",
                             rsp_id, rsp_data, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    // One cycle: sample grants just after the drive point, queue expected results.
    task automatic step(output logic g0, output logic g1);
        exp_t e;
        #1;
        g0 = req0_valid & req0_ready;
        g1 = req1_valid & req1_ready;
        if (g0 | g1) begin
            e.id   = g1;
            e.data = pwl(g1 ? req1_x : req0_x, m_xn, m_k, m_b);
            e.cyc  = cyc + LAT + 2;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic cfg_write(input int a, input int d);
        logic g0, g1;
        cfg_we    = 1'b1;
        cfg_addr  = 5'(a);
        cfg_wdata = W'(d);
        if (a < 9)       s_xn[a*W +: W]     = W'(d);
        else if (a < 19) s_k[(a-9)*W +: W]  = W'(d);
        else if (a < 29) s_b[(a-19)*W +: W] = W'(d);
        step(g0, g1);
        cfg_we = 1'b0;
    endtask

    task automatic wait_drain();
        logic g0, g1;
        for (int i = 0; i < 4 * LAT + 10 && sb.size() != 0; i++) step(g0, g1);
        step(g0, g1);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic wait_busy();
        logic g0, g1;
        for (int i = 0; i < 40 && cfg_busy === 1'b1; i++) step(g0, g1);
        compared++;
        if (cfg_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_timeout: cfg_busy=%0b, required 0", cfg_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 0;
        req0_valid = 0; req1_valid = 0; req0_x = '0; req1_x = '0;
        repeat (2) @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #1;
        compared++;
        if ({cfg_busy, tbl_valid, req0_ready, req1_ready, rsp_valid, rsp_id} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: busy/tv/rdy0/rdy1/rv/rid=%06b, required 000000",
                     {cfg_busy, tbl_valid, req0_ready, req1_ready, rsp_valid, rsp_id});
        end
        compared++;
        if (dp_x !== '0 || dp_xn !== '0 || dp_k !== '0 || dp_b !== '0 || rsp_data !== '0) begin
            mismatched++;
            $display("FAIL reset_data: dp_x=%0h dp_k=%0h rsp_data=%0h, required all 0",
                     dp_x, dp_k, rsp_data);
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_commit();
        logic g0, g1;
        req0_valid = 1; req1_valid = 1; req0_x = W'(5); req1_x = W'(6);
        for (int i = 0; i < 9; i++) cfg_write(i, 100 * i - 400);
        for (int i = 0; i < 10; i++) cfg_write(9 + i, i + 1);
        for (int i = 0; i < 10; i++) cfg_write(19 + i, 10 * i);
        #1;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            mismatched++;
            $display("FAIL init_ready: ready=%02b, required 00 before commit",
                     {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        cfg_commit = 1;
        step(g0, g1);
        cfg_commit = 0;
        compared++;
        if ({cfg_busy, tbl_valid} !== 2'b10) begin
            mismatched++;
            $display("FAIL commit_c1: busy/tv=%02b, required 10", {cfg_busy, tbl_valid});
        end
        step(g0, g1);
        m_xn = s_xn; m_k = s_k; m_b = s_b;
        compared++;
        if ({cfg_busy, tbl_valid} !== 2'b01) begin
            mismatched++;
            $display("FAIL commit_c2: busy/tv=%02b, required 01", {cfg_busy, tbl_valid});
        end
        compared++;
        if (dp_xn !== m_xn || dp_k !== m_k || dp_b !== m_b) begin
            mismatched++;
            $display("FAIL table_load: xn=%0h k=%0h b=%0h, required xn=%0h k=%0h b=%0h",
                     dp_xn, dp_k, dp_b, m_xn, m_k, m_b);
        end
    endtask

    task automatic test_both_valid();
        logic g0, g1;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1; req1_valid = 1;
            req0_x = W'(i); req1_x = W'(100 + i);
            step(g0, g1);
            compared++;
            if ({g0, g1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                mismatched++;
                $display("FAIL rr_alternate[%0d]: grants=%02b, required %02b", i, {g0, g1},
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
        end
        req0_valid = 0; req1_valid = 0;
        wait_drain();
    endtask

    task automatic test_req1_only();
        logic g0, g1;
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1; req1_x = W'(300 + i);
            step(g0, g1);
            compared++;
            if ({g0, g1} !== 2'b01) begin
                mismatched++;
                $display("FAIL req1_only[%0d]: grants=%02b, required 01", i, {g0, g1});
            end
        end
        req0_valid = 1; req0_x = W'(-150); req1_x = W'(-250);
        step(g0, g1);
        compared++;
        if ({g0, g1} !== 2'b10) begin
            mismatched++;
            $display("FAIL rr_after_req1: grants=%02b, required 10", {g0, g1});
        end
        step(g0, g1);
        compared++;
        if ({g0, g1} !== 2'b01) begin
            mismatched++;
            $display("FAIL rr_next: grants=%02b, required 01", {g0, g1});
        end
        req0_valid = 0; req1_valid = 0;
        wait_drain();
    endtask

    task automatic test_commit_inflight();
        logic g0, g1;
        logic [10*W-1:0] old_k;
        int busy_cyc = 0;
        bit done = 0;
        for (int i = 0; i < 10; i++) cfg_write(9 + i, 2 * i + 3);
        old_k = m_k;
        compared++;
        if (dp_k !== old_k) begin
            mismatched++;
            $display("FAIL shadow_isolated: dp_k=%0h, required %0h", dp_k, old_k);
        end
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req0_x = W'(-50 + 60 * i);
            if (i == 2) cfg_commit = 1;
            step(g0, g1);
            compared++;
            if (g0 !== 1'b1) begin
                mismatched++;
                $display("FAIL pre_commit_grant[%0d]: g0=%0b, required 1", i, g0);
            end
        end
        cfg_commit = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (cfg_busy === 1'b1) begin
                busy_cyc++;
                compared++;
                if (sb.size() != 0 && dp_k !== old_k) begin
                    mismatched++;
                    $display("FAIL early_swap: dp_k=%0h with %0d in flight, required %0h",
                             dp_k, sb.size(), old_k);
                end
                step(g0, g1);
                compared++;
                if (g0 !== 1'b0) begin
                    mismatched++;
                    $display("FAIL drain_ready: g0=%0b while busy, required 0", g0);
                end
            end else begin
                done = 1;
            end
        end
        m_xn = s_xn; m_k = s_k; m_b = s_b;
        compared++;
        if (busy_cyc != LAT + 3) begin
            mismatched++;
            $display("FAIL busy_len: %0d cycles, required %0d", busy_cyc, LAT + 3);
        end
        compared++;
        if (dp_k !== m_k) begin
            mismatched++;
            $display("FAIL new_table: dp_k=%0h, required %0h", dp_k, m_k);
        end
        step(g0, g1);
        compared++;
        if (g0 !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_restored: g0=%0b, required 1", g0);
        end
        req0_valid = 0;
        wait_drain();
    endtask

    task automatic test_we_in_update();
        logic g0, g1;
        cfg_commit = 1;
        step(g0, g1);
        cfg_commit = 0;
        step(g0, g1);
        compared++;
        if (cfg_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL update_busy: cfg_busy=%0b, required 1", cfg_busy);
        end
        m_xn = s_xn; m_k = s_k; m_b = s_b;
        cfg_write(9, 55);
        compared++;
        if (cfg_busy !== 1'b0 || dp_k !== m_k) begin
            mismatched++;
            $display("FAIL we_in_update: busy=%0b dp_k=%0h, required busy=0 dp_k=%0h",
                     cfg_busy, dp_k, m_k);
        end
        cfg_commit = 1;
        step(g0, g1);
        cfg_commit = 0;
        wait_busy();
        m_xn = s_xn; m_k = s_k; m_b = s_b;
        compared++;
        if (dp_k !== m_k || dp_k[W-1:0] !== W'(55)) begin
            mismatched++;
            $display("FAIL second_commit: dp_k=%0h, required %0h (k0=55)", dp_k, m_k);
        end
    endtask

    task automatic test_reset_midflight();
        logic g0, g1;
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1; req0_x = W'(20 + i);
            step(g0, g1);
        end
        req0_valid = 0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        s_xn = '0; s_k = '0; s_b = '0; m_xn = '0; m_k = '0; m_b = '0;
        #1;
        compared++;
        if ({cfg_busy, tbl_valid, rsp_valid, rsp_id} !== 4'b0 || dp_x !== '0 ||
            dp_k !== '0 || dp_xn !== '0 || dp_b !== '0 || rsp_data !== '0) begin
            mismatched++;
            $display("FAIL midreset_zero: busy=%0b tv=%0b rv=%0b dp_x=%0h dp_k=%0h, required all 0",
                     cfg_busy, tbl_valid, rsp_valid, dp_x, dp_k);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            req0_valid = 1; req1_valid = 1;
            compared++;
            if (rsp_valid !== 1'b0 || tbl_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL post_reset[%0d]: rsp_valid=%0b tbl_valid=%0b, required 0 0",
                         i, rsp_valid, tbl_valid);
            end
            step(g0, g1);
            compared++;
            if ({g0, g1} !== 2'b00) begin
                mismatched++;
                $display("FAIL post_reset_ready[%0d]: grants=%02b, required 00", i, {g0, g1});
            end
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_commit();
        test_both_valid();
        test_req1_only();
        test_commit_inflight();
        test_we_in_update();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL final_queue: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
